approx_recursive_mult_seq: RTL



---
 rtl/approx_recursive_mult_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/approx_recursive_mult_seq.sv
// approx_recursive_mult_seq
// Sequential recursive WIDTH x WIDTH unsigned multiplier. It computes one
// 4x4 sub-product per clock and accumulates it with an exact shifted add.
// Each 4x4 sub-product is built from 2x2 kernels. When approx_mode is set,
// the kernel returns 7 for 3x3; otherwise the kernel is exact.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, x, approx_mode latched at accept)
//   out_valid / out_ready result handshake; product held stable while out_valid
//   product               2*WIDTH result
//   err_flag, err_dist,   present only when ERROR_MONITOR_EN is defined:
//   mismatch_cnt          mismatch flag, |a*x - product|, and a saturating
//                         count of delivered mismatching results
//
// Optional feature macro: ERROR_MONITOR_EN
module approx_recursive_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   x,
  input  logic               approx_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
`ifdef ERROR_MONITOR_EN
  ,
  output logic               err_flag,
  output logic [2*WIDTH-1:0] err_dist,
  output logic [15:0]        mismatch_cnt
`endif
);

  localparam int NCH = WIDTH / 4;
  localparam int PW  = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, x_r;
  logic             mode_r;
  logic [PW-1:0]    acc;
  logic [1:0]       ci, cj;
  logic             last;
  logic [3:0]       a_chunk, x_chunk;
  logic [7:0]       sub;
  logic [PW-1:0]    term;

  function automatic logic [3:0] k2(input logic [1:0] p, input logic [1:0] q,
                                    input logic apx);
    if (apx && (p == 2'd3) && (q == 2'd3)) return 4'd7;
    return 4'(p) * 4'(q);
  endfunction

  function automatic logic [7:0] p4(input logic [3:0] p, input logic [3:0] q,
                                    input logic apx);
    return (8'(k2(p[3:2], q[3:2], apx)) << 4) +
           (8'(k2(p[3:2], q[1:0], apx)) << 2) +
           (8'(k2(p[1:0], q[3:2], apx)) << 2) +
            8'(k2(p[1:0], q[1:0], apx));
  endfunction

  assign last = (ci == 2'(NCH-1)) && (cj == 2'(NCH-1));

  always_comb begin
    a_chunk = 4'(a_r >> (4 * int'(ci)));
    x_chunk = 4'(x_r >> (4 * int'(cj)));
    sub     = p4(a_chunk, x_chunk, mode_r);
    term    = PW'(sub) << (4 * (int'(ci) + int'(cj)));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = MULT;
      MULT:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Gated with rst_n so in_ready is low while reset is asserted.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      x_r    <= '0;
      mode_r <= 1'b0;
      acc    <= '0;
      ci     <= '0;
      cj     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          a_r    <= a;
          x_r    <= x;
          mode_r <= approx_mode;
          acc    <= '0;
          ci     <= '0;
          cj     <= '0;
        end
        MULT: begin
          acc <= acc + term;
          if (cj == 2'(NCH-1)) begin
            cj <= '0;
            ci <= ci + 2'd1;
          end else begin
            cj <= cj + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ERROR_MONITOR_EN
  logic [PW-1:0] exact_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact_r      <= '0;
      mismatch_cnt <= '0;
    end else begin
      if (state == IDLE && in_valid)
        exact_r <= PW'(a) * PW'(x);
      if (out_valid && out_ready && err_flag && (mismatch_cnt != '1))
        mismatch_cnt <= mismatch_cnt + 16'd1;
    end
  end

  always_comb begin
    err_flag = 1'b0;
    err_dist = '0;
    if (out_valid) begin
      err_flag = (acc != exact_r);
      err_dist = (exact_r >= acc) ? (exact_r - acc) : (acc - exact_r);
    end
  end
`endif

endmodule
